sub_rr_arbiter: RTL and testbench
=================================

# sub_rr_arbiter

Round-robin arbiter that shares one `param_subtractor` instance among `NREQ` requesters. Each cycle it picks at most one pending request and latches that requester's operands. It registers the difference, borrow and requester id into a single-entry output slot drained by a valid/ready handshake. It sits between several datapath clients and the shared subtractor, giving fair access with one-cycle latency and one operation per cycle of throughput.

## Interface
- `WIDTH`, 8: operand and difference width, ≥1.
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, $clog2(NREQ): width of requester id.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester request; bit i pending while high.
- `a_in`  in  NREQ*WIDTH  minuend of requester i at bits [i*WIDTH +: WIDTH].
- `b_in`  in  NREQ*WIDTH  subtrahend of requester i, same packing.
- `gnt`  out  NREQ  one-hot acceptance strobe, combinational, same cycle as acceptance.
- `res_valid`  out  1  output slot holds a result.
- `res_ready`  in  1  consumer accepts result this cycle.
- `res_diff`  out  WIDTH  (a − b) mod 2^WIDTH.
- `res_borrow`  out  1  1 iff a < b, unsigned.
- `res_id`  out  IDW  index of the requester that produced the result.
- `op_count`  out  16  completed results (res_valid & res_ready), wraps 0xFFFF→0.

## Operation
- Slot FSM has two states.
  - EMPTY: res_valid = 0.
  - FULL: res_valid = 1.
- `can_accept` = EMPTY, or FULL with res_ready = 1 (drain and refill in the same cycle).
- When can_accept is true and any req bit is high, grant exactly one requester:
  - the first set bit scanning upward from `ptr+1`, wrapping modulo NREQ;
  - gnt[k] = 1 for that cycle;
  - at the clock edge, the slot loads a_in[k] − b_in[k], the borrow and id k; ptr ← k; state → FULL.
- When can_accept is false, gnt = 0 and ptr holds.
- When FULL, res_ready = 1 and no request is pending, the state goes to EMPTY.
- When FULL and res_ready = 0, all res_* outputs hold stable. No result is ever overwritten or dropped.
- Requester contract:
  - hold req and operands stable until gnt is seen;
  - req still high in the cycle after gnt counts as a new request.
- Fairness: a continuously pending requester is granted within NREQ acceptances.
- Arithmetic:
  - unsigned only;
  - diff truncated to WIDTH bits;
  - borrow = carry-out inverse of a + ~b + 1;
  - a = b gives diff 0, borrow 0;
  - 0 − (2^WIDTH − 1) gives diff 1, borrow 1.
- `op_count` increments on every res_valid & res_ready cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - res_valid = 0, res_diff = 0, res_borrow = 0, res_id = 0, op_count = 0;
  - ptr = NREQ−1, so requester 0 has first priority;
  - gnt = 0 while rst_n is low.
- Reset asserted mid-operation: the pending result is discarded. Requesters must re-request after release.
- First edge after release is an ordinary cycle.
- Latency: gnt in cycle t → res_valid = 1 with the result from cycle t+1.
- Throughput: with res_ready held high, one result per cycle.
- Back-pressure: res_ready = 0 with FULL → gnt = 0 in that cycle.
- res_ready while EMPTY is ignored.
- gnt depends combinationally on req, res_ready and state. There is no combinational path from a_in/b_in to any output.

## Test plan
- Reset, then req = 4'b0001, a = 8'h05, b = 8'h03, res_ready = 1:
  - gnt = 0001 in cycle 0;
  - cycle 1: res_valid = 1, diff = 0x02, borrow = 0, id = 0;
  - op_count = 1 after the drain.
- Borrow and edges:
  - a = 0x00, b = 0xFF → diff 0x01, borrow 1;
  - a = 0x7A, b = 0x7A → diff 0, borrow 0;
  - a = 0xFF, b = 0x00 → diff 0xFF, borrow 0.
- All four req held high, res_ready = 1 for 8 cycles:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, …;
  - res_id sequence 0, 1, 2, 3, 0, …;
  - one result per cycle.
- res_ready = 0 for 5 cycles while FULL with req = 1010 pending:
  - gnt = 0 and res_* stable throughout;
  - on res_ready = 1, requester 1 or 3 is granted per ptr in that cycle;
  - no result is lost.
- rst_n pulsed low mid-stream while FULL:
  - res_valid drops immediately, without waiting for a clock edge;
  - op_count = 0 and gnt = 0;
  - after release with req = 1000, the first grant goes to requester 3.
- Drive 65 536 completed results: op_count wraps to 0x0000.

Source files
------------

// File: rtl/sub_rr_arbiter_if.sv
// Request/response bundle between the requesters, the shared-subtractor
// arbiter and the result consumer.
interface sub_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_diff;
  logic                  res_borrow;
  logic [IDW-1:0]        res_id;
  logic [15:0]           op_count;

  modport master (
    output req, a_in, b_in, res_ready,
    input  gnt, res_valid, res_diff, res_borrow, res_id, op_count
  );

  modport slave (
    input  req, a_in, b_in, res_ready,
    output gnt, res_valid, res_diff, res_borrow, res_id, op_count
  );
endinterface

// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter sharing one subtractor among NREQ requesters, with a
// single-entry valid/ready result slot and a completed-result counter.
module param_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);
  logic [WIDTH:0] sum;

  // a + ~b + 1; a missing carry-out means a < b
  assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_o   = sum[WIDTH-1:0];
  assign borrow_o = ~sum[WIDTH];
endmodule

module sub_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  sub_rr_arbiter_if.slave   bus
);
  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic [IDW-1:0]   id_q;
  logic [15:0]      op_count_q;

  logic             res_valid;
  logic             can_accept;
  logic             grant_en;
  logic             drain;
  logic             hi_found, lo_found;
  logic [IDW-1:0]   hi_idx, lo_idx, sel_idx;
  logic [WIDTH-1:0] a_sel, b_sel, sub_diff;
  logic             sub_borrow;

  // Rotating priority: lowest pending index above ptr, else lowest pending overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (bus.req[i] && !hi_found && (IDW'(i) > ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDW'(i);
      end
      if (bus.req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel_idx) begin
        a_sel = bus.a_in[i*WIDTH +: WIDTH];
        b_sel = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  param_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a_i      (a_sel),
    .b_i      (b_sel),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant_en) begin
      state_d = FULL;
      ptr_d   = sel_idx;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // gnt is masked by rst_n so nothing is accepted while reset is held
  always_comb begin
    res_valid  = (state_q == FULL);
    can_accept = (state_q == EMPTY) || bus.res_ready;
    drain      = res_valid && bus.res_ready;
    grant_en   = can_accept && (|bus.req) && rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      id_q     <= '0;
    end else if (grant_en) begin
      diff_q   <= sub_diff;
      borrow_q <= sub_borrow;
      id_q     <= sel_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (drain) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign bus.gnt        = grant_en ? (NREQ'(1) << sel_idx) : '0;
  assign bus.res_valid  = res_valid;
  assign bus.res_diff   = diff_q;
  assign bus.res_borrow = borrow_q;
  assign bus.res_id     = id_q;
  assign bus.op_count   = op_count_q;
endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Directed bench for sub_rr_arbiter: reset, arithmetic edges, rotation,
// back-pressure, asynchronous reset mid-stream and op_count wrap.
module tb_sub_rr_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sub_rr_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

  sub_rr_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int unsigned k, input logic [7:0] a, input logic [7:0] b);
    bus.a_in[k*8 +: 8] = a;
    bus.b_in[k*8 +: 8] = b;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] diff, input logic borrow,
                         input logic [1:0] id);
    chk({tag, "_valid"},  32'(bus.res_valid),  32'd1);
    chk({tag, "_diff"},   32'(bus.res_diff),   32'(diff));
    chk({tag, "_borrow"}, 32'(bus.res_borrow), 32'(borrow));
    chk({tag, "_id"},     32'(bus.res_id),     32'(id));
  endtask

  logic [7:0] ev_a   [3] = '{8'h00, 8'h7A, 8'hFF};
  logic [7:0] ev_b   [3] = '{8'hFF, 8'h7A, 8'h00};
  logic [7:0] ev_d   [3] = '{8'h01, 8'h00, 8'hFF};
  logic       ev_bor [3] = '{1'b1, 1'b0, 1'b0};
  logic [7:0] rr_d   [4] = '{8'h10, 8'h1F, 8'h2E, 8'h3D};

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req       = 4'b0001;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b0;

    // reset state, gnt suppressed even with a request pending
    @(negedge clk); #1;
    chk("rst_valid",  32'(bus.res_valid),  32'd0);
    chk("rst_diff",   32'(bus.res_diff),   32'd0);
    chk("rst_borrow", 32'(bus.res_borrow), 32'd0);
    chk("rst_id",     32'(bus.res_id),     32'd0);
    chk("rst_opcnt",  32'(bus.op_count),   32'd0);
    chk("rst_gnt",    32'(bus.gnt),        32'd0);

    // basic transaction on requester 0
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b0001;
    set_ops(0, 8'h05, 8'h03);
    bus.res_ready = 1'b1;
    #1 chk("basic_gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = 4'b0000;
    #1 chk_res("basic", 8'h02, 1'b0, 2'd0);
    chk("basic_gnt_idle", 32'(bus.gnt), 32'd0);
    @(negedge clk); #1;
    chk("basic_opcnt", 32'(bus.op_count), 32'd1);
    chk("basic_empty", 32'(bus.res_valid), 32'd0);

    // arithmetic edges through requester 2
    for (int n = 0; n < 3; n++) begin
      bus.req = 4'b0100;
      set_ops(2, ev_a[n], ev_b[n]);
      #1 chk("edge_gnt", 32'(bus.gnt), 32'b0100);
      @(negedge clk);
      bus.req = 4'b0000;
      #1 chk_res("edge", ev_d[n], ev_bor[n], 2'd2);
      @(negedge clk);
    end
    #1 chk("edge_opcnt", 32'(bus.op_count), 32'd4);

    // all requesters pending; ptr is 2 so rotation starts at 3
    for (int unsigned k = 0; k < 4; k++) set_ops(k, 8'((k + 1) * 16), 8'(k));
    bus.req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      #1 chk("rr_gnt", 32'(bus.gnt), 32'd1 << ((3 + n) % 4));
      if (n > 0) chk_res("rr", rr_d[(2 + n) % 4], 1'b0, 2'((2 + n) % 4));
      else       chk("rr_first_empty", 32'(bus.res_valid), 32'd0);
      @(negedge clk);
    end
    bus.req = 4'b0000;
    #1 chk_res("rr_last", rr_d[2], 1'b0, 2'd2);
    @(negedge clk); #1;
    chk("rr_opcnt", 32'(bus.op_count), 32'd12);

    // back-pressure with 1010 pending; ptr=2 so 3 wins first
    bus.req = 4'b1010;
    bus.res_ready = 1'b0;
    #1 chk("bp_gnt_first", 32'(bus.gnt), 32'b1000);
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      #1 chk("bp_gnt_stall", 32'(bus.gnt), 32'd0);
      chk_res("bp_hold", 8'h3D, 1'b0, 2'd3);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_gnt_release", 32'(bus.gnt), 32'b0010);
    chk_res("bp_drain", 8'h3D, 1'b0, 2'd3);
    @(negedge clk);
    bus.req = 4'b0000;
    #1 chk_res("bp_next", 8'h1F, 1'b0, 2'd1);
    @(negedge clk); #1;
    chk("bp_opcnt", 32'(bus.op_count), 32'd14);

    // asynchronous reset while FULL
    bus.req = 4'b0001;
    bus.res_ready = 1'b0;
    #1 chk("ar_gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk); #1;
    chk("ar_full", 32'(bus.res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(bus.res_valid), 32'd0);
    chk("ar_opcnt",      32'(bus.op_count),  32'd0);
    chk("ar_gnt_low",    32'(bus.gnt),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1000;
    #1 chk("ar_post_gnt", 32'(bus.gnt), 32'b1000);
    @(negedge clk);
    bus.req = 4'b0000;
    bus.res_ready = 1'b1;
    #1 chk_res("ar_post", 8'h3D, 1'b0, 2'd3);
    @(negedge clk); #1;
    chk("ar_post_opcnt", 32'(bus.op_count), 32'd1);

    // op_count wrap: fresh reset, then one result per cycle
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus.req = 4'b0001;
    set_ops(0, 8'h09, 8'h04);
    repeat (65536) @(posedge clk);
    @(negedge clk); #1;
    chk("wrap_ffff", 32'(bus.op_count), 32'hFFFF);
    chk_res("wrap_res", 8'h05, 1'b0, 2'd0);
    @(negedge clk); #1;
    chk("wrap_zero", 32'(bus.op_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
